// File: rtl/cnt_rr_sched.sv
// cnt_rr_sched: round-robin scheduler sharing one up/down loadable counter among NREQ requesters.
// Ports: clk, rst (sync, active-high); req/req_load/req_down/req_ticks per-requester job inputs;
// gnt one-hot grant, busy, done pulse with done_id/result/wrap/err; cnt_load_en/cnt_load/cnt_down
// drive the counter, cnt_count is read back from it.
module cnt_rr_sched #(
  parameter int NREQ = 4,
  parameter int WIDTH = 4,
  parameter int TW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    req_load,
  input  logic [NREQ-1:0]          req_down,
  input  logic [NREQ*TW-1:0]       req_ticks,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic [WIDTH-1:0]         result,
  output logic                     wrap,
  output logic                     err,
  output logic                     cnt_load_en,
  output logic [WIDTH-1:0]         cnt_load,
  output logic                     cnt_down,
  input  logic [WIDTH-1:0]         cnt_count
);
  localparam int IW = $clog2(NREQ);
  localparam int SW = (TW > WIDTH ? TW : WIDTH) + 1;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, DONE} state_t;
  state_t state, nxt;
  logic [IW-1:0] ptr, win, pick;
  logic [WIDTH-1:0] l, e;
  logic d;
  logic [TW-1:0] t, tick;
  logic [SW-1:0] sum;
  // Lowest set request above ptr wins; otherwise lowest at or below ptr (wrap-around).
  always_comb begin
    pick = '0;
    for (int j = NREQ-1; j >= 0; j--) if (req[j] && IW'(j) <= ptr) pick = IW'(j);
    for (int j = NREQ-1; j >= 0; j--) if (req[j] && IW'(j) > ptr) pick = IW'(j);
  end
  always_comb begin
    nxt = state == IDLE ? (|req ? LOAD : IDLE)
        : state == LOAD ? (t != '0 ? RUN : CAPT)
        : state == RUN  ? (tick == TW'(1) ? CAPT : RUN)
        : state == CAPT ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  assign e = d ? l - WIDTH'(t) : l + WIDTH'(t);
  assign sum = SW'(l) + SW'(t);
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IW'(NREQ-1);
      win <= '0;
      l <= '0;
      d <= 1'b0;
      t <= '0;
      tick <= '0;
      result <= '0;
      wrap <= 1'b0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && |req) begin
        ptr <= pick;
        win <= pick;
        l <= req_load[pick*WIDTH +: WIDTH];
        d <= req_down[pick];
        t <= req_ticks[pick*TW +: TW];
        tick <= req_ticks[pick*TW +: TW];
      end
      if (state == RUN) tick <= tick - TW'(1);
      if (state == CAPT) begin
        result <= cnt_count;
        err <= cnt_count != e;
        wrap <= d ? SW'(t) > SW'(l) : (sum >> WIDTH) != '0;
      end
    end
  end
  assign gnt = state == IDLE ? '0 : NREQ'(1) << win;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign done_id = win;
  assign cnt_load_en = state == LOAD;
  assign cnt_load = l;
  assign cnt_down = d;
endmodule

// File: doc/cnt_rr_sched.md
Name: cnt_rr_sched

Overview:
- Round-robin scheduler that shares one up/down loadable counter (counter_ud, WIDTH bits) between NREQ requesters.
- Each granted job loads a start value into the counter and lets it run TICKS cycles in a chosen direction.
- Returns the final count, a wrap flag and a consistency-error flag to the requester.
- Sits between requester logic and the counter's load_en/load/down/count pins.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, counter width; must match the counter instance.
- TW, 8, width of the per-job tick count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req  in  NREQ  per-requester request level.
- req_load  in  NREQ*WIDTH  start value; slice i belongs to requester i.
- req_down  in  NREQ  direction; 1 = count down.
- req_ticks  in  NREQ*TW  number of counting cycles.
- gnt  out  NREQ  one-hot grant; high from LOAD through DONE.
- busy  out  1  state != IDLE.
- done  out  1  high for exactly the DONE cycle.
- done_id  out  clog2(NREQ)  index of the finished requester; valid while done.
- result  out  WIDTH  captured counter value; valid while done, held until the next capture.
- wrap  out  1  job crossed the 0 / 2^WIDTH-1 boundary; valid while done.
- err  out  1  counter value disagreed with the expected value; valid while done.
- cnt_load_en  out  1  to counter load_en.
- cnt_load  out  WIDTH  to counter load.
- cnt_down  out  1  to counter down.
- cnt_count  in  WIDTH  from counter count.

Behaviour:
- Counter contract:
  - Counter loads cnt_load on an edge where cnt_load_en=1.
  - Otherwise it steps ±1 per edge, modulo 2^WIDTH, direction set by cnt_down.
- States: IDLE, LOAD, RUN, CAPT, DONE.
- Reset:
  - state=IDLE; gnt=0, done=0, done_id=0, result=0, wrap=0, err=0.
  - cnt_load_en=0, cnt_load=0, cnt_down=0.
  - RR pointer = NREQ-1, so requester 0 wins first.
- rst is honoured in any state, including mid-job. The job is dropped with no done pulse, and the counter is left as-is.
- IDLE:
  - req sampled only here.
  - If any req is set, pick the first set bit searching from pointer+1 upward, with wrap.
  - Latch that requester's load, down and ticks; set pointer = winner; go to LOAD.
  - req lines are ignored in every other state.
- LOAD (1 cycle): cnt_load_en=1, cnt_load=L, cnt_down=D, gnt one-hot. Next state is RUN if T>0, else CAPT.
- RUN (T cycles):
  - cnt_load_en=0, cnt_down=D held.
  - Internal tick counter loads T and decrements each cycle; leave to CAPT on the cycle it reads 1.
- CAPT (1 cycle):
  - cnt_count is sampled here, after exactly T steps.
  - Expected E = (L+T) mod 2^WIDTH if D=0, else (L-T) mod 2^WIDTH, using T truncated to TW bits.
  - At the end of CAPT register: result <= cnt_count, err <= (cnt_count != E).
  - wrap <= (D=0 and L+T > 2^WIDTH-1) or (D=1 and T > L).
- DONE (1 cycle): done=1, done_id = winner, gnt still held; then go to IDLE.
  - A requester must drop req in the cycle after it sees done, otherwise it is re-arbitrated in that IDLE cycle.
- Latency, request seen in IDLE at cycle 0:
  - LOAD at cycle 1; RUN at cycles 2..T+1; CAPT at T+2; DONE at T+3; IDLE at T+4.
  - For T=0: CAPT at cycle 2, DONE at cycle 3.
- Simultaneous requests: exactly one grant, per the RR order. Back-to-back jobs are separated by one IDLE cycle.
- Requester operands need not stay stable after the IDLE sample; they are latched.

Test Plan:
- Reset then req[0], L=0x3, D=0, T=5 → gnt=0001 at cycle 1, done at cycle 8, result=0x8, wrap=0, err=0, done_id=0.
- req[2], L=0x2, D=1, T=4 → result=0xE, wrap=1, err=0.
- req[1], L=0xF, D=0, T=0 → no RUN state, done at cycle 3, result=0xF, wrap=0.
- req=1111 held continuously, then each requester drops on its own done → grant order 0,1,2,3, with one IDLE cycle between jobs.
- Assert rst for one cycle during RUN of a T=10 job → next cycle IDLE, gnt=0, done never pulses, pointer back to NREQ-1.
- Bench forces cnt_count to 0x0 during CAPT of job L=0x1, D=0, T=3 → result=0x0, err=1.
